// File: rtl/regfile_issue_if.sv
// Bundle of decode-side issue, execute-side operand, writeback and PC signals
// exchanged with the register file / issue stage.
interface regfile_issue_if #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int PC_W = 8
);
  localparam int IW = $clog2(NREG);

  logic                 issue_valid;
  logic                 issue_ready;
  logic [IW-1:0]        src1_idx;
  logic [IW-1:0]        src2_idx;
  logic [DW-1:0]        imm_val;
  logic                 src2_is_imm;
  logic                 dst_we;
  logic [IW-1:0]        dst_idx;
  logic                 op_valid;
  logic                 op_ready;
  logic [DW-1:0]        src1_val;
  logic [DW-1:0]        src2_val;
  logic                 op_dst_we;
  logic [IW-1:0]        op_dst_idx;
  logic [PC_W-1:0]      op_pc;
  logic                 wb_valid;
  logic [IW-1:0]        wb_idx;
  logic [DW-1:0]        wb_val;
  logic                 pc_load;
  logic [PC_W-1:0]      pc_target;
  logic [PC_W-1:0]      pc;
  logic [NREG*DW-1:0]   regs;
  logic [NREG-1:0]      busy;

  modport master (
    output issue_valid, src1_idx, src2_idx, imm_val, src2_is_imm, dst_we, dst_idx,
    output op_ready, wb_valid, wb_idx, wb_val, pc_load, pc_target,
    input  issue_ready, op_valid, src1_val, src2_val, op_dst_we, op_dst_idx, op_pc,
    input  pc, regs, busy
  );

  modport slave (
    input  issue_valid, src1_idx, src2_idx, imm_val, src2_is_imm, dst_we, dst_idx,
    input  op_ready, wb_valid, wb_idx, wb_val, pc_load, pc_target,
    output issue_ready, op_valid, src1_val, src2_val, op_dst_we, op_dst_idx, op_pc,
    output pc, regs, busy
  );
endinterface

// File: rtl/regfile_issue.sv
// Register file + operand-issue stage: busy scoreboard with RAW/WAW stall,
// same-cycle writeback bypass, PC tracking and a valid/ready bundle to execute.
module regfile_issue #(
  parameter int DW      = 8,
  parameter int NREG    = 4,
  parameter int PC_W    = 8,
  parameter int R0_ZERO = 0
) (
  input logic           iRST,
  input logic           iCLK_WB,
  regfile_issue_if.slave bus
);
  localparam int IW = $clog2(NREG);

  logic [DW-1:0]      regs_q [NREG];
  logic [NREG*DW-1:0] regs_flat;
  logic [NREG-1:0]    busy_q;
  logic [NREG-1:0]    busy_nxt;
  logic [NREG-1:0]    wb_hit;
  logic [NREG-1:0]    busy_eff;
  logic [PC_W-1:0]    pc_q;
  logic               hazard;
  logic               ready;
  logic               accept;
  logic [DW-1:0]      src1_rd;
  logic [DW-1:0]      src2_rd;

  logic               vld_p1;
  logic               dst_we_p1;
  logic [DW-1:0]      src1_p1;
  logic [DW-1:0]      src2_p1;
  logic [IW-1:0]      dst_idx_p1;
  logic [PC_W-1:0]    pc_p1;

  function automatic logic hardwired_zero(input logic [IW-1:0] idx);
    return (R0_ZERO != 0) && (idx == '0);
  endfunction

  // ---- stage p0: scoreboard lookup, operand read with writeback bypass ----
  always_comb begin
    for (int i = 0; i < NREG; i++)
      wb_hit[i] = bus.wb_valid && (bus.wb_idx == IW'(i));
  end

  assign busy_eff = busy_q & ~wb_hit;

  always_comb begin
    src1_rd = regs_q[bus.src1_idx];
    if (wb_hit[bus.src1_idx])
      src1_rd = bus.wb_val;
    if (hardwired_zero(bus.src1_idx))
      src1_rd = '0;
    src2_rd = regs_q[bus.src2_idx];
    if (wb_hit[bus.src2_idx])
      src2_rd = bus.wb_val;
    if (hardwired_zero(bus.src2_idx))
      src2_rd = '0;
    if (bus.src2_is_imm)
      src2_rd = bus.imm_val;
  end

  assign hazard = busy_eff[bus.src1_idx]
                | (~bus.src2_is_imm & busy_eff[bus.src2_idx])
                | (bus.dst_we & busy_eff[bus.dst_idx]);
  assign ready  = ~iRST & ~bus.pc_load & ~hazard & (~vld_p1 | bus.op_ready);
  assign accept = bus.issue_valid & ready;

  // A writeback clearing the same bit that a new writer claims loses to the set.
  always_comb begin
    busy_nxt = busy_eff;
    if (accept && bus.dst_we && !hardwired_zero(bus.dst_idx))
      busy_nxt[bus.dst_idx] = 1'b1;
  end

  always_ff @(posedge iCLK_WB or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else if (bus.wb_valid && !hardwired_zero(bus.wb_idx)) begin
      regs_q[bus.wb_idx] <= bus.wb_val;
    end
  end

  always_ff @(posedge iCLK_WB or posedge iRST) begin
    if (iRST) begin
      busy_q <= '0;
      pc_q   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      if (accept)
        pc_q <= pc_q + 1'b1;
      else if (bus.pc_load)
        pc_q <= bus.pc_target;
      if (accept)
        vld_p1 <= 1'b1;
      else if (bus.op_ready)
        vld_p1 <= 1'b0;
    end
  end

  // ---- stage p1: operand bundle held until execute takes it ----
  always_ff @(posedge iCLK_WB or posedge iRST) begin
    if (iRST) begin
      src1_p1    <= '0;
      src2_p1    <= '0;
      dst_we_p1  <= 1'b0;
      dst_idx_p1 <= '0;
      pc_p1      <= '0;
    end else if (accept) begin
      src1_p1    <= src1_rd;
      src2_p1    <= src2_rd;
      dst_we_p1  <= bus.dst_we;
      dst_idx_p1 <= bus.dst_idx;
      pc_p1      <= pc_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++)
      regs_flat[i*DW +: DW] = regs_q[i];
  end

  assign bus.issue_ready = ready;
  assign bus.op_valid    = vld_p1;
  assign bus.src1_val    = src1_p1;
  assign bus.src2_val    = src2_p1;
  assign bus.op_dst_we   = dst_we_p1;
  assign bus.op_dst_idx  = dst_idx_p1;
  assign bus.op_pc       = pc_p1;
  assign bus.pc          = pc_q;
  assign bus.regs        = regs_flat;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_regfile_issue.sv
// Bench for regfile_issue: two instances (R0_ZERO=0 and 1) share stimulus; a
// behavioural model feeds per-instance scoreboards checked by a monitor.
module tb_regfile_issue;
  localparam int DW = 8, NREG = 4, PC_W = 8, IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic            issue_valid, src2_is_imm, dst_we, op_ready, wb_valid, pc_load;
  logic [IW-1:0]   src1_idx, src2_idx, dst_idx, wb_idx;
  logic [DW-1:0]   imm_val, wb_val;
  logic [PC_W-1:0] pc_target;

  logic               d_ready [2];
  logic               d_opv   [2];
  logic               d_we    [2];
  logic [DW-1:0]      d_s1    [2];
  logic [DW-1:0]      d_s2    [2];
  logic [IW-1:0]      d_dst   [2];
  logic [PC_W-1:0]    d_oppc  [2];
  logic [PC_W-1:0]    d_pc    [2];
  logic [NREG*DW-1:0] d_regs  [2];
  logic [NREG-1:0]    d_busy  [2];

  regfile_issue_if #(.DW(DW), .NREG(NREG), .PC_W(PC_W)) bus [2] ();

  for (genvar k = 0; k < 2; k++) begin : g_dut
    assign bus[k].issue_valid = issue_valid;
    assign bus[k].src1_idx    = src1_idx;
    assign bus[k].src2_idx    = src2_idx;
    assign bus[k].imm_val     = imm_val;
    assign bus[k].src2_is_imm = src2_is_imm;
    assign bus[k].dst_we      = dst_we;
    assign bus[k].dst_idx     = dst_idx;
    assign bus[k].op_ready    = op_ready;
    assign bus[k].wb_valid    = wb_valid;
    assign bus[k].wb_idx      = wb_idx;
    assign bus[k].wb_val      = wb_val;
    assign bus[k].pc_load     = pc_load;
    assign bus[k].pc_target   = pc_target;
    assign d_ready[k] = bus[k].issue_ready;
    assign d_opv[k]   = bus[k].op_valid;
    assign d_we[k]    = bus[k].op_dst_we;
    assign d_s1[k]    = bus[k].src1_val;
    assign d_s2[k]    = bus[k].src2_val;
    assign d_dst[k]   = bus[k].op_dst_idx;
    assign d_oppc[k]  = bus[k].op_pc;
    assign d_pc[k]    = bus[k].pc;
    assign d_regs[k]  = bus[k].regs;
    assign d_busy[k]  = bus[k].busy;

    regfile_issue #(.DW(DW), .NREG(NREG), .PC_W(PC_W), .R0_ZERO(k)) dut (
      .iRST    (rst),
      .iCLK_WB (clk),
      .bus     (bus[k])
    );
  end

  typedef struct packed {
    logic [DW-1:0]   s1;
    logic [DW-1:0]   s2;
    logic            we;
    logic [IW-1:0]   dst;
    logic [PC_W-1:0] pc;
  } bundle_t;

  // Reference state: instance k has register 0 hardwired to zero when k==1.
  logic [DW-1:0]   m_regs [2][NREG];
  logic            m_busy [2][NREG];
  logic [PC_W-1:0] m_pc   [2];
  logic            m_opv  [2];
  bundle_t         sb     [2][$];

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  function automatic bit is_zero_reg(input int k, input int idx);
    return (k == 1) && (idx == 0);
  endfunction

  function automatic logic [DW-1:0] m_read(input int k, input int idx);
    if (is_zero_reg(k, idx)) return '0;
    if (wb_valid && int'(wb_idx) == idx) return wb_val;
    return m_regs[k][idx];
  endfunction

  function automatic logic m_effbusy(input int k, input int idx);
    return m_busy[k][idx] && !(wb_valid && int'(wb_idx) == idx);
  endfunction

  function automatic logic m_ready(input int k);
    logic hz;
    hz = m_effbusy(k, int'(src1_idx))
      || (!src2_is_imm && m_effbusy(k, int'(src2_idx)))
      || (dst_we && m_effbusy(k, int'(dst_idx)));
    return !rst && !pc_load && !hz && (!m_opv[k] || op_ready);
  endfunction

  function automatic logic [NREG*DW-1:0] m_regs_flat(input int k);
    logic [NREG*DW-1:0] r;
    for (int i = 0; i < NREG; i++) r[i*DW +: DW] = m_regs[k][i];
    return r;
  endfunction

  function automatic logic [NREG-1:0] m_busy_vec(input int k);
    logic [NREG-1:0] b;
    for (int i = 0; i < NREG; i++) b[i] = m_busy[k][i];
    return b;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[k][i] = '0;
        m_busy[k][i] = 1'b0;
      end
      m_pc[k]  = '0;
      m_opv[k] = 1'b0;
      sb[k].delete();
    end
  endtask

  task automatic m_step(input int k);
    bundle_t b;
    logic    acc;
    acc = issue_valid && m_ready(k);
    if (acc) begin
      b.s1  = m_read(k, int'(src1_idx));
      b.s2  = src2_is_imm ? imm_val : m_read(k, int'(src2_idx));
      b.we  = dst_we;
      b.dst = dst_idx;
      b.pc  = m_pc[k];
      sb[k].push_back(b);
    end
    if (wb_valid) begin
      if (!is_zero_reg(k, int'(wb_idx))) m_regs[k][wb_idx] = wb_val;
      m_busy[k][wb_idx] = 1'b0;
    end
    if (acc) begin
      m_opv[k] = 1'b1;
      m_pc[k]  = m_pc[k] + 1'b1;
      if (dst_we && !is_zero_reg(k, int'(dst_idx))) m_busy[k][dst_idx] = 1'b1;
    end else if (op_ready) begin
      m_opv[k] = 1'b0;
    end
    if (pc_load) m_pc[k] = pc_target;
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic cycle();
    #1;
    for (int k = 0; k < 2; k++) chk("issue_ready", k, d_ready[k], m_ready(k));
    @(posedge clk);
    for (int k = 0; k < 2; k++) m_step(k);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("pc", k, d_pc[k], m_pc[k]);
      chk("op_valid", k, d_opv[k], m_opv[k]);
      chk("busy", k, d_busy[k], m_busy_vec(k));
      chk("regs", k, d_regs[k], m_regs_flat(k));
    end
  endtask

  task automatic expect_ready(input logic v);
    #1;
    for (int k = 0; k < 2; k++) chk("ready_const", k, d_ready[k], v);
  endtask

  task automatic idle();
    issue_valid = 0; src1_idx = 0; src2_idx = 0; imm_val = 0; src2_is_imm = 0;
    dst_we = 0; dst_idx = 0; op_ready = 1; wb_valid = 0; wb_idx = 0; wb_val = 0;
    pc_load = 0; pc_target = 0;
  endtask

  task automatic issue(input int s1, input int s2, input bit imm, input logic [DW-1:0] iv,
                       input bit we, input int dst);
    issue_valid = 1; src1_idx = IW'(s1); src2_idx = IW'(s2); src2_is_imm = imm;
    imm_val = iv; dst_we = we; dst_idx = IW'(dst);
  endtask

  task automatic wb(input int idx, input logic [DW-1:0] v);
    wb_valid = 1; wb_idx = IW'(idx); wb_val = v;
  endtask

  task automatic chk_zero();
    for (int k = 0; k < 2; k++) begin
      chk("rst_pc", k, d_pc[k], 0);
      chk("rst_op_valid", k, d_opv[k], 0);
      chk("rst_ready", k, d_ready[k], 0);
      chk("rst_src1", k, d_s1[k], 0);
      chk("rst_src2", k, d_s2[k], 0);
      chk("rst_dst_we", k, d_we[k], 0);
      chk("rst_dst_idx", k, d_dst[k], 0);
      chk("rst_op_pc", k, d_oppc[k], 0);
      chk("rst_regs", k, d_regs[k], 0);
      chk("rst_busy", k, d_busy[k], 0);
    end
  endtask

  // Monitor: each bundle consumed by execute must match the next expected one.
  initial begin
    bundle_t e;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        if (!rst && d_opv[k] && op_ready) begin
          if (sb[k].size() == 0) begin
            chk("sb_unexpected_bundle", k, 1, 0);
          end else begin
            e = sb[k].pop_front();
            chk("bundle_src1", k, d_s1[k], e.s1);
            chk("bundle_src2", k, d_s2[k], e.s2);
            chk("bundle_dst_we", k, d_we[k], e.we);
            chk("bundle_dst_idx", k, d_dst[k], e.dst);
            chk("bundle_pc", k, d_oppc[k], e.pc);
          end
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    chk_zero();
    rst = 1'b0;

    wb(1, 8'd5); cycle();
    wb(2, 8'd7); cycle();
    idle(); issue(1, 2, 0, 0, 0, 0); cycle();
    for (int k = 0; k < 2; k++) begin
      chk("first_op_valid", k, d_opv[k], 1);
      chk("first_src1", k, d_s1[k], 5);
      chk("first_src2", k, d_s2[k], 7);
      chk("first_op_pc", k, d_oppc[k], 0);
      chk("first_pc", k, d_pc[k], 1);
    end

    issue(1, 1, 0, 0, 1, 3); cycle();
    for (int k = 0; k < 2; k++) chk("busy3_set", k, d_busy[k][3], 1);
    issue(3, 0, 1, 8'h01, 0, 0);
    expect_ready(0); cycle();
    expect_ready(0); cycle();
    wb(3, 8'd9);
    expect_ready(1); cycle();
    for (int k = 0; k < 2; k++) begin
      chk("bypass_src1", k, d_s1[k], 9);
      chk("busy3_clr", k, d_busy[k][3], 0);
    end

    idle(); issue(1, 0, 1, 8'h33, 0, 0); cycle();
    op_ready = 0;
    for (int n = 0; n < 2; n++) begin
      expect_ready(0); cycle();
      for (int k = 0; k < 2; k++) begin
        chk("hold_src1", k, d_s1[k], 5);
        chk("hold_src2", k, d_s2[k], 8'h33);
        chk("hold_valid", k, d_opv[k], 1);
      end
    end
    idle(); cycle();

    issue(1, 0, 1, 8'h00, 1, 2); cycle();
    issue(1, 0, 1, 8'hA5, 1, 2); wb(2, 8'h11);
    expect_ready(1); cycle();
    for (int k = 0; k < 2; k++) begin
      chk("set_wins_busy2", k, d_busy[k][2], 1);
      chk("imm_src2", k, d_s2[k], 8'hA5);
      chk("wb_r2", k, d_regs[k][2*DW +: DW], 8'h11);
    end

    idle(); pc_load = 1; pc_target = 8'hFF; cycle();
    for (int k = 0; k < 2; k++) chk("pc_load_ff", k, d_pc[k], 8'hFF);
    idle(); issue(1, 0, 1, 8'h44, 0, 0); cycle();
    for (int k = 0; k < 2; k++) begin
      chk("pc_wrap", k, d_pc[k], 0);
      chk("op_pc_ff", k, d_oppc[k], 8'hFF);
    end
    pc_load = 1; pc_target = 8'h40;
    expect_ready(0); cycle();
    for (int k = 0; k < 2; k++) begin
      chk("pc_load_40", k, d_pc[k], 8'h40);
      chk("pc_load_noissue", k, d_opv[k], 0);
    end

    idle(); wb(0, 8'd3); cycle();
    chk("r0_written", 0, d_regs[0][DW-1:0], 3);
    chk("r0_zero", 1, d_regs[1][DW-1:0], 0);
    idle(); issue(1, 0, 1, 8'h00, 1, 0); wb(2, 8'h01); cycle();
    chk("r0_busy", 0, d_busy[0][0], 1);
    chk("r0_never_busy", 1, d_busy[1][0], 0);
    idle(); wb(0, 8'd4); cycle();

    for (int n = 0; n < 400; n++) begin
      issue_valid = ($urandom_range(0, 9) < 7);
      src1_idx    = IW'($urandom_range(0, NREG-1));
      src2_idx    = IW'($urandom_range(0, NREG-1));
      src2_is_imm = $urandom_range(0, 1) == 1;
      imm_val     = DW'($urandom);
      dst_we      = $urandom_range(0, 1) == 1;
      dst_idx     = IW'($urandom_range(0, NREG-1));
      op_ready    = ($urandom_range(0, 3) != 0);
      wb_valid    = ($urandom_range(0, 9) < 4);
      wb_idx      = IW'($urandom_range(0, NREG-1));
      wb_val      = DW'($urandom);
      pc_load     = ($urandom_range(0, 15) == 0);
      pc_target   = PC_W'($urandom);
      cycle();
    end

    idle();
    for (int i = 0; i < NREG; i++) begin
      wb(i, DW'(i + 16)); cycle();
    end
    idle(); issue(1, 0, 1, 8'h00, 1, 3); cycle();
    idle(); issue(3, 0, 1, 8'h00, 0, 0); cycle();
    #3 rst = 1'b1;
    #1 chk_zero();
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
